// File: rtl/seq_ctrl_pkg.sv
// Shared types and the combinational step function of the three-bit sequence circuit.
package seq_ctrl_pkg;

  localparam int unsigned SEQ_W = 3;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} ctrl_state_t;

  // State bits are packed as {S0,S1,S2}, so S0 is the MSB.
  function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] s);
    logic s0, s1, s2;
    s0 = s[2];
    s1 = s[1];
    s2 = s[0];
    return {~(s1 | s2), s0 | s2, s0 ^ s1};
  endfunction

endpackage

// File: rtl/seq_core.sv
// Three-bit sequence circuit: state register with seed load and step enable.
module seq_core
  import seq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [SEQ_W-1:0] seed,
  input  logic             step,
  output logic [SEQ_W-1:0] state,
  output logic [SEQ_W-1:0] next_state,
  output logic             y
);

  assign next_state = seq_next(state);
  assign y          = state[2] & state[1];

  // Core state: load has priority over stepping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/seq_step_ctrl.sv
// Run controller: loads a seed, steps the core, records y history and counts.
module seq_step_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned HIST_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        seed,
  input  logic [CNT_W-1:0]  num_steps,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_o,
  output logic              y,
  output logic [HIST_W-1:0] y_hist,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic [CNT_W-1:0]  steps_done,
  output logic              fixed_pt
);

  ctrl_state_t      state_q, state_nxt;
  logic [2:0]       seed_q;
  logic [CNT_W-1:0] num_q;
  logic [2:0]       core_next;
  logic             load, step;
  logic             y_next, at_fixed, last_step;

  seq_core u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .seed       (seed_q),
    .step       (step),
    .state      (state_o),
    .next_state (core_next),
    .y          (y)
  );

  assign y_next    = core_next[2] & core_next[1];
  assign at_fixed  = (core_next == state_o);
  assign last_step = ((steps_done + CNT_W'(1)) == num_q);

  assign busy = (state_q == LOAD) || (state_q == RUN);
  assign done = (state_q == DONE);

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode and core strobes.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        load      = 1'b1;
        state_nxt = (num_q == '0) ? DONE : RUN;
      end
      RUN: begin
        if (!hold) begin
          step = 1'b1;
          if (last_step || at_fixed) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Run parameters are captured only when a start is accepted in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q <= '0;
      num_q  <= '0;
    end else if (state_q == IDLE && start) begin
      seed_q <= seed;
      num_q  <= num_steps;
    end
  end

  // Result registers: cleared on LOAD, updated per executed step, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_hist     <= '0;
      ones_cnt   <= '0;
      steps_done <= '0;
      fixed_pt   <= 1'b0;
    end else if (load) begin
      y_hist     <= '0;
      ones_cnt   <= '0;
      steps_done <= '0;
      fixed_pt   <= 1'b0;
    end else if (step) begin
      y_hist     <= {y_hist[HIST_W-2:0], y_next};
      ones_cnt   <= ones_cnt + CNT_W'(y_next);
      steps_done <= steps_done + CNT_W'(1);
      if (at_fixed) fixed_pt <= 1'b1;
    end
  end

endmodule
